// File: rtl/uart_echo_top.sv
// uart_echo_top: FPGA UART loopback. 8N1 receiver, one-byte holding buffer, 8N1 transmitter.
// Every correctly framed byte is retransmitted unchanged.
//
// Ports:
//   clk       system clock, all logic on rising edge
//   reset     synchronous, active-high reset
//   sw_0      RX enable (1 = receive), sampled directly
//   sw_1      TX enable (1 = transmit), sampled directly
//   uart_rxd  serial input, idle high, asynchronous to clk
//   uart_txd  serial output, idle high
//   led       last byte accepted by RX
//   rx_valid  one-cycle pulse when a byte is accepted
//   tx_busy   high while TX is sending a frame
//
// RX and TX FSM states (shared encoding):
//   state   | meaning
//   S_IDLE  | line idle; RX waits for a start edge, TX waits for a buffered byte
//   S_START | RX: waiting half a bit to re-check start; TX: driving the start bit
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | RX: sampling mid stop bit; TX: driving the stop bit

module uart_echo_top #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_0,
  input  logic       sw_1,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] led,
  output logic       rx_valid,
  output logic       tx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  // Down-counter reload values; a phase ends when the counter reaches zero.
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronizer (resets to the idle-high line level)
  // ---------------------------------------------------------------
  logic rxd_meta;
  logic rxd_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // ---------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------
  state_t           rx_state;
  state_t           rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit_idx;
  logic [7:0]       rx_shift;
  logic             rx_cnt_zero;
  logic             rx_shift_en;
  logic             rx_accept;

  assign rx_cnt_zero = (rx_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) rx_state <= S_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (sw_0 && !rxd_sync)                rx_next = S_START;
      S_START: if (rx_cnt_zero)                      rx_next = rxd_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cnt_zero && rx_bit_idx == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_cnt_zero)                      rx_next = S_IDLE;
      default:                                       rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_en = 1'b0;
    rx_accept   = 1'b0;
    case (rx_state)
      S_DATA:  rx_shift_en = rx_cnt_zero;
      // The stop bit is judged at its midpoint; the rest of it is not waited for.
      S_STOP:  rx_accept   = rx_cnt_zero && rxd_sync;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt     <= '0;
      rx_bit_idx <= 3'd0;
      rx_shift   <= 8'h00;
      led        <= 8'h00;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= rx_accept;
      if (rx_state == S_IDLE) begin
        // Preloaded with the half-bit delay so START begins counting immediately.
        rx_cnt     <= HALF_LOAD;
        rx_bit_idx <= 3'd0;
      end else if (rx_cnt_zero) begin
        rx_cnt <= BIT_LOAD;
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
      if (rx_shift_en) begin
        rx_shift   <= {rxd_sync, rx_shift[7:1]};
        rx_bit_idx <= rx_bit_idx + 3'd1;
      end
      if (rx_accept) led <= rx_shift;
    end
  end

  // ---------------------------------------------------------------
  // One-entry holding buffer
  // ---------------------------------------------------------------
  logic       buf_full;
  logic [7:0] buf_data;
  logic       tx_load;

  // tx_load implies buf_full, so a byte arriving in the load cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
    end else if (tx_load) begin
      buf_full <= 1'b0;
    end else if (rx_accept && !buf_full) begin
      buf_full <= 1'b1;
      buf_data <= rx_shift;
    end
  end

  // ---------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------
  state_t           tx_state;
  state_t           tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit_idx;
  logic [7:0]       tx_shift;
  logic             tx_cnt_zero;

  assign tx_cnt_zero = (tx_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (buf_full && sw_1)                  tx_next = S_START;
      S_START: if (tx_cnt_zero)                       tx_next = S_DATA;
      S_DATA:  if (tx_cnt_zero && tx_bit_idx == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_cnt_zero)                       tx_next = S_IDLE;
      default:                                        tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_load  = 1'b0;
    uart_txd = 1'b1;
    tx_busy  = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_load = buf_full && sw_1;
        tx_busy = 1'b0;
      end
      S_START: uart_txd = 1'b0;
      S_DATA:  uart_txd = tx_shift[0];
      S_STOP:  uart_txd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt     <= '0;
      tx_bit_idx <= 3'd0;
      tx_shift   <= 8'h00;
    end else begin
      if (tx_state == S_IDLE) begin
        // Full bit period ready for the start bit that follows a load.
        tx_cnt     <= BIT_LOAD;
        tx_bit_idx <= 3'd0;
        if (tx_load) tx_shift <= buf_data;
      end else if (tx_cnt_zero) begin
        tx_cnt <= BIT_LOAD;
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
      if (tx_state == S_DATA && tx_cnt_zero) begin
        tx_shift   <= {1'b0, tx_shift[7:1]};
        tx_bit_idx <= tx_bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_top.sv
// tb_uart_echo_top: directed self-checking bench for uart_echo_top at a reduced bit rate
// (16 clocks per bit) so that frames stay short.

module tb_uart_echo_top;

  localparam int CLK_HZ   = 1600;
  localparam int BIT_RATE = 100;
  localparam int CPB      = 16;
  localparam int HALF     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_0 = 1'b0;
  logic       sw_1 = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic [7:0] led;
  logic       rx_valid;
  logic       tx_busy;

  uart_echo_top #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_0     (sw_0),
    .sw_1     (sw_1),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .led      (led),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Line observers, sampled on the falling edge.
  int   cyc = 0;
  int   rxv_count = 0;
  int   rxv_cycle = -1;
  int   txd_low_count = 0;
  int   fall_cycle = -1;
  logic prev_txd = 1'b1;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_txd <= uart_txd;
    if (rx_valid === 1'b1) begin
      rxv_count <= rxv_count + 1;
      rxv_cycle <= cyc;
    end
    if (!reset && uart_txd !== 1'b1) txd_low_count <= txd_low_count + 1;
    if (!reset && prev_txd === 1'b1 && uart_txd === 1'b0) fall_cycle <= cyc;
  end

  // Echo decoder: samples each transmitted bit at its midpoint.
  logic [7:0] echo_q[$];
  logic       start_q[$];
  logic       stop_q[$];

  initial begin
    logic [7:0] b;
    logic       st;
    logic       sp;
    forever begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
        repeat (HALF) @(negedge clk);
        st = uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        sp = uart_txd;
        echo_q.push_back(b);
        start_q.push_back(st);
        stop_q.push_back(sp);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is on a falling edge; returns on the falling edge ending the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw_0 = 1'b1;
    sw_1 = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    tests_run++; if (led !== 8'h00) begin tests_failed++; $display("FAIL reset_led: got %h expected 00", led); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_echo();
    int rb, eb, lat;
    rb = rxv_count;
    eb = echo_q.size();
    send_byte(8'hA5, 1'b1);
    tests_run++; if (rxv_count - rb != 1) begin tests_failed++; $display("FAIL a5_rx_valid_pulses: got %0d expected 1", rxv_count - rb); end
    tests_run++; if (led !== 8'hA5) begin tests_failed++; $display("FAIL a5_led: got %h expected a5", led); end
    lat = fall_cycle - rxv_cycle;
    tests_run++; if (lat < 0 || lat > 2) begin tests_failed++; $display("FAIL a5_latency: got %0d cycles expected 0..2", lat); end
    wait_bits(11);
    tests_run++;
    if (echo_q.size() - eb != 1) begin
      tests_failed++; $display("FAIL a5_echo_count: got %0d expected 1", echo_q.size() - eb);
    end else begin
      tests_run++; if (echo_q[eb] !== 8'hA5) begin tests_failed++; $display("FAIL a5_echo_data: got %h expected a5", echo_q[eb]); end
      tests_run++; if (start_q[eb] !== 1'b0) begin tests_failed++; $display("FAIL a5_echo_start: got %b expected 0", start_q[eb]); end
      tests_run++; if (stop_q[eb] !== 1'b1) begin tests_failed++; $display("FAIL a5_echo_stop: got %b expected 1", stop_q[eb]); end
    end
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL a5_tx_idle: got %b expected 0", tx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[20];
    int rb, eb;
    rb = rxv_count;
    eb = echo_q.size();
    for (int i = 0; i < 20; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) send_byte(bytes[i], 1'b1);
    wait_bits(12);
    tests_run++; if (rxv_count - rb != 20) begin tests_failed++; $display("FAIL b2b_rx_count: got %0d expected 20", rxv_count - rb); end
    tests_run++;
    if (echo_q.size() - eb != 20) begin
      tests_failed++; $display("FAIL b2b_echo_count: got %0d expected 20", echo_q.size() - eb);
    end else begin
      for (int i = 0; i < 20; i++) begin
        tests_run++;
        if (echo_q[eb + i] !== bytes[i] || stop_q[eb + i] !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_echo_%0d: got %h stop %b expected %h stop 1", i, echo_q[eb + i], stop_q[eb + i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int rb, lb, eb;
    rb = rxv_count;
    lb = txd_low_count;
    uart_rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    uart_rxd = 1'b1;
    wait_bits(2);
    tests_run++; if (rxv_count != rb) begin tests_failed++; $display("FAIL glitch_rx_valid: got %0d pulses expected 0", rxv_count - rb); end
    tests_run++; if (txd_low_count != lb) begin tests_failed++; $display("FAIL glitch_txd: got %0d low cycles expected 0", txd_low_count - lb); end
    // RX must be back in IDLE: a following clean frame is received normally.
    eb = echo_q.size();
    send_byte(8'h5A, 1'b1);
    wait_bits(11);
    tests_run++; if (led !== 8'h5A) begin tests_failed++; $display("FAIL glitch_recover_led: got %h expected 5a", led); end
    tests_run++;
    if (echo_q.size() - eb != 1) begin
      tests_failed++; $display("FAIL glitch_recover_echo_count: got %0d expected 1", echo_q.size() - eb);
    end else begin
      tests_run++; if (echo_q[eb] !== 8'h5A) begin tests_failed++; $display("FAIL glitch_recover_echo: got %h expected 5a", echo_q[eb]); end
    end
  endtask

  task automatic test_framing_error();
    int rb, lb, eb;
    rb = rxv_count;
    lb = txd_low_count;
    eb = echo_q.size();
    send_byte(8'h3C, 1'b0);
    wait_bits(12);
    tests_run++; if (rxv_count != rb) begin tests_failed++; $display("FAIL frame_rx_valid: got %0d pulses expected 0", rxv_count - rb); end
    tests_run++; if (led !== 8'h5A) begin tests_failed++; $display("FAIL frame_led: got %h expected 5a", led); end
    tests_run++; if (echo_q.size() != eb) begin tests_failed++; $display("FAIL frame_echo: got %0d frames expected 0", echo_q.size() - eb); end
    tests_run++; if (txd_low_count != lb) begin tests_failed++; $display("FAIL frame_txd: got %0d low cycles expected 0", txd_low_count - lb); end
  endtask

  task automatic test_tx_disable();
    int rb, lb, eb;
    sw_1 = 1'b0;
    rb = rxv_count;
    lb = txd_low_count;
    eb = echo_q.size();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_bits(2);
    tests_run++; if (led !== 8'h22) begin tests_failed++; $display("FAIL txdis_led: got %h expected 22", led); end
    tests_run++; if (rxv_count - rb != 2) begin tests_failed++; $display("FAIL txdis_rx_count: got %0d expected 2", rxv_count - rb); end
    tests_run++; if (txd_low_count != lb) begin tests_failed++; $display("FAIL txdis_txd: got %0d low cycles expected 0", txd_low_count - lb); end
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL txdis_busy: got %b expected 0", tx_busy); end
    sw_1 = 1'b1;
    wait_bits(25);
    tests_run++;
    if (echo_q.size() - eb != 1) begin
      tests_failed++; $display("FAIL txdis_echo_count: got %0d expected 1", echo_q.size() - eb);
    end else begin
      tests_run++; if (echo_q[eb] !== 8'h11) begin tests_failed++; $display("FAIL txdis_echo_data: got %h expected 11", echo_q[eb]); end
    end
  endtask

  task automatic test_rx_disable_and_reset();
    int rb, lb;
    sw_0 = 1'b0;
    rb = rxv_count;
    lb = txd_low_count;
    send_byte(8'h55, 1'b1);
    wait_bits(2);
    tests_run++; if (rxv_count != rb) begin tests_failed++; $display("FAIL rxdis_rx_valid: got %0d pulses expected 0", rxv_count - rb); end
    tests_run++; if (txd_low_count != lb) begin tests_failed++; $display("FAIL rxdis_txd: got %0d low cycles expected 0", txd_low_count - lb); end
    tests_run++; if (led !== 8'h22) begin tests_failed++; $display("FAIL rxdis_led: got %h expected 22", led); end
    sw_0 = 1'b1;
    send_byte(8'h96, 1'b1);
    wait_bits(3);
    tests_run++; if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL midecho_busy: got %b expected 1", tx_busy); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL abort_txd: got %b expected 1", uart_txd); end
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", tx_busy); end
    tests_run++; if (led !== 8'h00) begin tests_failed++; $display("FAIL abort_led: got %h expected 00", led); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lb = txd_low_count;
    wait_bits(12);
    tests_run++; if (txd_low_count != lb) begin tests_failed++; $display("FAIL abort_no_echo: got %0d low cycles expected 0", txd_low_count - lb); end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_tx_disable();
    test_rx_disable_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
